sos_sequencer: RTL and testbench
================================

Name: sos_sequencer

Overview:
- Controller that sequences the SOS Morse waveform onto the serial line that sos_driver consumes.
- Converts a one-cycle start request into a timed mark/space pattern ("... --- ..."), repeated N times with word gaps between repeats.
- Provides busy/done handshake and abort so a host FSM can schedule transmissions.

Parameters:
- UNIT_CYCLES, 4, clock cycles per Morse time unit (>=1).
- CNT_W, 8, width of the unit prescaler counter; must hold UNIT_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a transmission; sampled only in IDLE.
- repeat_cnt  input  4  number of SOS messages to send; latched on accepted start; 0 is treated as 1.
- abort  input  1  synchronous cancel; highest priority after reset.
- dataOut  output  1  Morse line: 1 = mark, 0 = space.
- busy  output  1  high while a transmission is in progress.
- done  output  1  one-cycle pulse on normal completion.
- elem_idx  output  4  current element 0..8 (S=0..2, O=3..5, S=6..8); 0 in IDLE.

Behaviour:
- Reset (rst_n=0, async): dataOut=0, busy=0, done=0, elem_idx=0, FSM=IDLE, counters=0.
- All outputs are registered.
- Timing rules, in units:
  - dot mark = 1, dash mark = 3.
  - intra-letter gap = 1; inter-letter gap (after elements 2 and 5) = 3; word gap between repeats = 7.
  - No gap after the final element of the final repeat.
- One message spans 27 units; N repeats span N*27 + (N-1)*7 units.
- FSM states: IDLE, MARK, GAP, WORD_GAP, DONE.
  - IDLE: start=1 and abort=0 at an edge → MARK, elem_idx=0, reps_left=max(repeat_cnt,1)-1.
  - dataOut=1 and busy=1 from the cycle after that edge (relative cycle 1).
  - MARK → GAP at end of mark length if elements remain.
  - MARK at element 8 → WORD_GAP if reps_left>0, else DONE.
  - GAP → MARK with elem_idx+1.
  - WORD_GAP → MARK with elem_idx=0 and reps_left-1.
  - DONE lasts exactly 1 cycle (done=1, busy=0, dataOut=0), then IDLE.
- Unit prescaler counts 0..UNIT_CYCLES-1 and emits unit_tick on wrap; it restarts at 0 on every state entry, so every mark/space is an exact multiple of UNIT_CYCLES.
- start while busy or in DONE: ignored, no queueing.
- abort in any non-IDLE state: next cycle IDLE, dataOut=0, busy=0, elem_idx=0, no done pulse.
- start and abort together in IDLE: abort wins, stays IDLE.
- A new start is accepted in the first IDLE cycle after DONE or after abort.
- repeat_cnt changes during busy have no effect.
- reps_left never underflows.

Decomposition:
- Shared package/header sos_pkg:
  - FSM state encodings.
  - DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7.
  - MSG_ELEMS=9 and the 9-bit dash mask 9'b000111000 (bit i=1 → element i is a dash).
  - Letter-boundary element indices 2 and 5.
- Sub-module sos_unit_timer: prescaler with a clear input and a unit_tick output, parameterised by UNIT_CYCLES.
- Unit counter and FSM stay in sos_sequencer.

Test Plan:
- Single message (UNIT_CYCLES=4, repeat_cnt=1): start sampled at edge 0 → dataOut=1 in cycles 1-4, 0 in 5-8, 1 in 9-12, first dash in cycles 33-44, last mark ends at cycle 108. Expected totals: 60 high cycles, busy=1 in cycles 1-108, done=1 only in cycle 109, elem_idx reaches 8.
- Repeat (repeat_cnt=2): second message's first mark starts at cycle 137 after 28 low cycles (word gap); last mark ends at cycle 244; done in cycle 245; 120 total high cycles.
- repeat_cnt=0: waveform and done timing identical to the repeat_cnt=1 case.
- Abort in the middle of the first dash (cycle 38): from cycle 39 dataOut=0, busy=0, elem_idx=0, and done is never asserted. start at cycle 40 begins a fresh message in cycle 41.
- Start while busy (cycle 50) is ignored, with the waveform unchanged. start+abort together in IDLE → stays IDLE and busy stays 0.
- rst_n asserted low during a mark (cycle 10) → dataOut, busy and done go 0 immediately without a clock edge. After release, the block sits in IDLE until a new start.

Source files
------------

// File: rtl/sos_pkg.sv
// Shared definitions for the SOS Morse sequencer: FSM state encoding,
// element/gap lengths in Morse units and helpers that map an element
// index to its mark length and the gap that follows it.
package sos_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MARK     = 3'd1,
    ST_GAP      = 3'd2,
    ST_WORD_GAP = 3'd3,
    ST_DONE     = 3'd4
  } sos_state_e;

  localparam int unsigned DOT_UNITS        = 1;
  localparam int unsigned DASH_UNITS       = 3;
  localparam int unsigned ELEM_GAP_UNITS   = 1;
  localparam int unsigned LETTER_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS   = 7;

  localparam int unsigned MSG_ELEMS  = 9;
  localparam logic [3:0]  LAST_ELEM  = 4'd8;
  localparam logic [8:0]  DASH_MASK  = 9'b000111000;
  localparam logic [3:0]  LETTER_END_A = 4'd2;
  localparam logic [3:0]  LETTER_END_B = 4'd5;

  // Unit counts fit in 3 bits (largest is the 7-unit word gap).
  function automatic logic [2:0] mark_units(input logic [3:0] idx);
    if (idx < 4'(MSG_ELEMS) && DASH_MASK[idx]) return 3'(DASH_UNITS);
    return 3'(DOT_UNITS);
  endfunction

  function automatic logic [2:0] gap_units(input logic [3:0] idx);
    if (idx == LETTER_END_A || idx == LETTER_END_B) return 3'(LETTER_GAP_UNITS);
    return 3'(ELEM_GAP_UNITS);
  endfunction

endpackage

// File: rtl/sos_unit_timer.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 and pulses unit_tick_o on the
// last count. clr_i forces the count back to 0 on the next edge.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   clr_i        restart the unit from zero
//   unit_tick_o  high in the final cycle of each unit
module sos_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic unit_tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign unit_tick_o = (cnt_q == CNT_W'(UNIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || unit_tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sos_sequencer.sv
// SOS Morse sequencer: turns a one-cycle start into N repeats of
// "... --- ..." on dataOut, with busy/done handshake and abort.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start        transmission request (honoured only in IDLE)
//   repeat_cnt   message count, latched on start (0 acts as 1)
//   abort        synchronous cancel
//   dataOut      Morse line, 1 = mark
//   busy         transmission in progress
//   done         one-cycle pulse on normal completion
//   elem_idx     current element 0..8, 0 in IDLE
//
// state    | meaning
// IDLE     | waiting for start
// MARK     | line high for the current element
// GAP      | intra/inter-letter space after an element
// WORD_GAP | 7-unit space between repeats
// DONE     | single-cycle completion pulse
module sos_sequencer
  import sos_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] repeat_cnt,
  input  logic       abort,
  output logic       dataOut,
  output logic       busy,
  output logic       done,
  output logic [3:0] elem_idx
);

  sos_state_e state_q, state_d;
  logic [3:0] elem_q, elem_d;
  logic [3:0] reps_q, reps_d;
  // Units remaining in the current mark/space, minus one (down-counter).
  logic [2:0] units_q, units_d;
  logic       data_q, data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       unit_tick;
  logic       last_unit;

  // Prescaler restarts on every state entry and is held while idle so the
  // first mark is a full unit long.
  sos_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      ((state_d != state_q) || (state_q == ST_IDLE)),
    .unit_tick_o(unit_tick)
  );

  assign last_unit = unit_tick && (units_q == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      reps_q  <= '0;
      units_q <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      reps_q  <= reps_d;
      units_q <= units_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    reps_d  = reps_q;
    units_d = units_q;
    if (unit_tick && units_q != 3'd0) units_d = units_q - 3'd1;

    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
      elem_d  = '0;
      reps_d  = '0;
      units_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d = ST_MARK;
            elem_d  = '0;
            reps_d  = (repeat_cnt == 4'd0) ? 4'd0 : repeat_cnt - 4'd1;
            units_d = mark_units(4'd0) - 3'd1;
          end
        end
        ST_MARK: begin
          if (last_unit) begin
            if (elem_q != LAST_ELEM) begin
              state_d = ST_GAP;
              units_d = gap_units(elem_q) - 3'd1;
            end else if (reps_q != 4'd0) begin
              state_d = ST_WORD_GAP;
              units_d = 3'(WORD_GAP_UNITS - 1);
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_GAP: begin
          if (last_unit) begin
            state_d = ST_MARK;
            elem_d  = elem_q + 4'd1;
            units_d = mark_units(elem_q + 4'd1) - 3'd1;
          end
        end
        ST_WORD_GAP: begin
          if (last_unit) begin
            state_d = ST_MARK;
            elem_d  = '0;
            if (reps_q != 4'd0) reps_d = reps_q - 4'd1;
            units_d = mark_units(4'd0) - 3'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          elem_d  = '0;
        end
        default: begin
          state_d = ST_IDLE;
          elem_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    data_d = (state_d == ST_MARK);
    busy_d = (state_d == ST_MARK) || (state_d == ST_GAP) || (state_d == ST_WORD_GAP);
    done_d = (state_d == ST_DONE);
  end

  assign dataOut  = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign elem_idx = elem_q;

endmodule

// File: tb/tb_sos_sequencer.sv
module tb_sos_sequencer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] repeat_cnt;
  logic       abort;
  logic       dataOut;
  logic       busy;
  logic       done;
  logic [3:0] elem_idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit       d;
    bit       b;
    bit       dn;
    bit       e_chk;
    int       e;
  } exp_t;

  exp_t exq[$];

  sos_sequencer #(.UNIT_CYCLES(U), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .repeat_cnt(repeat_cnt),
    .abort     (abort),
    .dataOut   (dataOut),
    .busy      (busy),
    .done      (done),
    .elem_idx  (elem_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected per-cycle trace of one full transmission, starting at the cycle
  // after the accepted start, ending with the done cycle.
  function automatic void build_model(input int n);
    exp_t x;
    int   reps;
    exq.delete();
    reps = (n == 0) ? 1 : n;
    for (int r = 0; r < reps; r++) begin
      for (int e = 0; e < 9; e++) begin
        int mlen, glen;
        mlen = (e >= 3 && e <= 5) ? 3 : 1;    // the O is dashes
        glen = (e == 2 || e == 5) ? 3 : 1;
        for (int c = 0; c < mlen * U; c++) begin
          x = '{d: 1, b: 1, dn: 0, e_chk: 1, e: e};
          exq.push_back(x);
        end
        if (e < 8) begin
          for (int c = 0; c < glen * U; c++) begin
            x = '{d: 0, b: 1, dn: 0, e_chk: 1, e: e};
            exq.push_back(x);
          end
        end else if (r < reps - 1) begin
          for (int c = 0; c < 7 * U; c++) begin
            x = '{d: 0, b: 1, dn: 0, e_chk: 1, e: e};
            exq.push_back(x);
          end
        end
      end
    end
    x = '{d: 0, b: 0, dn: 1, e_chk: 0, e: 0};
    exq.push_back(x);
  endfunction

  task automatic check_cycle(input string tag, input int cyc, input exp_t x);
    n_checks++;
    if (dataOut !== x.d || busy !== x.b || done !== x.dn ||
        (x.e_chk && elem_idx !== 4'(x.e))) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got data=%b busy=%b done=%b elem=%0d, want data=%b busy=%b done=%b elem=%0d",
               tag, cyc, dataOut, busy, done, elem_idx, x.d, x.b, x.dn, x.e);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    exp_t z;
    z = '{d: 0, b: 0, dn: 0, e_chk: 1, e: 0};
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check_cycle(tag, i, z);
    end
  endtask

  // Caller has start=1 driven; the next edge is the accepting edge. Returns
  // one cycle into the done pulse with start=0.
  task automatic run_msg(input string tag, input int n, input bit noise, input int high_exp);
    int highs;
    int hi_idx;
    highs = 0;
    hi_idx = 0;
    build_model(n);
    for (int i = 0; i < exq.size(); i++) begin
      @(posedge clk); #1;
      check_cycle(tag, i + 1, exq[i]);
      if (dataOut === 1'b1) highs++;
      if (noise) begin
        start      = 1'($urandom_range(0, 1));
        repeat_cnt = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (highs != high_exp) begin
      n_fail++;
      $display("FAIL %s_high_count: got %0d, want %0d", tag, highs, high_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; repeat_cnt = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dataOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || elem_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: got data=%b busy=%b done=%b elem=%0d, want 0 0 0 0",
               dataOut, busy, done, elem_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    check_idle("reset_idle", 4);
  endtask

  task automatic test_single();
    repeat_cnt = 4'd1; start = 1'b1;
    run_msg("single", 1, 1'b0, 60);
    check_idle("single_after", 3);
  endtask

  task automatic test_repeat();
    repeat_cnt = 4'd2; start = 1'b1;
    run_msg("repeat2", 2, 1'b0, 120);
    check_idle("repeat2_after", 2);
  endtask

  task automatic test_zero();
    repeat_cnt = 4'd0; start = 1'b1;
    run_msg("repeat0", 0, 1'b0, 60);
    check_idle("repeat0_after", 2);
  endtask

  // Random repeat count with start/repeat_cnt toggling while busy.
  task automatic test_random_noise();
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 3);
      repeat_cnt = 4'(n); start = 1'b1;
      run_msg("noise", n, 1'b1, 60 * n);
      check_idle("noise_after", 2);
    end
  endtask

  task automatic test_abort();
    exp_t z;
    z = '{d: 0, b: 0, dn: 0, e_chk: 1, e: 0};
    build_model(1);
    repeat_cnt = 4'd1; start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_cycle("abort_pre", c, exq[c - 1]);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_cycle("abort_c39", 39, z);
    @(posedge clk); #1;
    check_cycle("abort_c40", 40, z);
    start = 1'b1;
    run_msg("abort_restart", 1, 1'b0, 60);
    check_idle("abort_after", 2);
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1; repeat_cnt = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort_idle", 6);
  endtask

  task automatic test_back_to_back();
    repeat_cnt = 4'd1; start = 1'b1;
    run_msg("b2b_first", 1, 1'b0, 60);
    start = 1'b1;                 // presented during DONE: must be ignored
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || dataOut !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start_in_done: got busy=%b data=%b done=%b, want 0 0 0",
               busy, dataOut, done);
    end
    run_msg("b2b_second", 1, 1'b0, 60);
    check_idle("b2b_after", 2);
  endtask

  task automatic test_async_reset();
    build_model(1);
    repeat_cnt = 4'd1; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_cycle("arst_pre", c, exq[c - 1]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dataOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || elem_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%b busy=%b done=%b elem=%0d, want 0 0 0 0",
               dataOut, busy, done, elem_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    check_idle("arst_idle", 8);
    start = 1'b1;
    run_msg("arst_restart", 1, 1'b0, 60);
    check_idle("arst_after", 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_zero();
    test_random_noise();
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
